// File: rtl/minterm_scanner_if.sv
// rtl/minterm_scanner_if.sv - scan control and result bundle for minterm_scanner
// Parameter: N_IN - number of function inputs (1..6)
// Signals:
//   start  - begin a scan (honoured only when idle)
//   abort  - cancel a scan in progress
//   f_in   - function-under-test result for the current vec
//   vec    - input combination driven to the function, MSB is the first variable
//   busy   - scan in progress
//   done   - one-cycle pulse at scan completion
//   mask   - sum-of-minterms mask, bit i is f(vec=i)
//   ones   - number of set bits in mask
// Modports: master = harness side, slave = scanner side.
interface minterm_scanner_if #(
  parameter int N_IN = 3
);
  logic                   start;
  logic                   abort;
  logic                   f_in;
  logic [N_IN-1:0]        vec;
  logic                   busy;
  logic                   done;
  logic [(1<<N_IN)-1:0]   mask;
  logic [N_IN:0]          ones;

  modport master (
    output start, abort, f_in,
    input  vec, busy, done, mask, ones
  );

  modport slave (
    input  start, abort, f_in,
    output vec, busy, done, mask, ones
  );
endinterface

// File: rtl/minterm_scanner.sv
// rtl/minterm_scanner.sv - sequential truth-table reader building a minterm mask and ones count
// Parameters:
//   N_IN   - number of function inputs (1..6)
//   SETTLE - extra wait cycles per vector before f_in is sampled (0..15)
// Ports:
//   clk - clock, all state changes on the rising edge
//   rst - asynchronous active-high reset
//   bus - minterm_scanner_if slave: start/abort/f_in in, vec/busy/done/mask/ones out
module minterm_scanner #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  minterm_scanner_if.slave   bus
);

  localparam int              NV       = 1 << N_IN;
  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
  localparam logic [3:0]      SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    DONE
  } state_t;

  state_t            state;
  logic [3:0]        wcnt;
  logic [N_IN-1:0]   vec;
  logic              busy;
  logic              done;
  logic [NV-1:0]     mask;
  logic [N_IN:0]     ones;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wcnt  <= 4'd0;
      vec   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      mask  <= '0;
      ones  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            vec   <= '0;
            mask  <= '0;
            ones  <= '0;
            wcnt  <= 4'd0;
            busy  <= 1'b1;
            state <= APPLY;
          end
        end

        APPLY: begin
          // Abort wins over a sample falling due on the same edge.
          if (bus.abort) begin
            vec   <= '0;
            mask  <= '0;
            ones  <= '0;
            wcnt  <= 4'd0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (wcnt < SETTLE_C) begin
            wcnt <= wcnt + 4'd1;
          end else begin
            mask[vec] <= bus.f_in;
            ones      <= ones + {{N_IN{1'b0}}, bus.f_in};
            wcnt      <= 4'd0;
            // vec parks on the last minterm rather than wrapping.
            if (vec == VEC_LAST) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              vec <= vec + 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.vec  = vec;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.mask = mask;
  assign bus.ones = ones;

endmodule
